traffic_lamp_driver: RTL and testbench



---
 rtl/traffic_lamp_driver_if.sv | 25 ++
 rtl/traffic_lamp_driver.sv | 121 ++++++++++++
 tb/tb_traffic_lamp_driver.sv | 131 +++++++++++++
 3 files changed

// File: rtl/traffic_lamp_driver_if.sv
// Signal bundle between the intersection light controller and the lamp driver:
// four traffic_light codes plus fault clear in, four lamp vectors plus status out.
interface traffic_lamp_driver_if;
  logic [1:0] north;
  logic [1:0] south;
  logic [1:0] east;
  logic [1:0] west;
  logic       fault_clr;
  logic [3:0] lamp_n;
  logic [3:0] lamp_s;
  logic [3:0] lamp_e;
  logic [3:0] lamp_w;
  logic       fault;
  logic       blink;

  modport master (
    output north, south, east, west, fault_clr,
    input  lamp_n, lamp_s, lamp_e, lamp_w, fault, blink
  );

  modport slave (
    input  north, south, east, west, fault_clr,
    output lamp_n, lamp_s, lamp_e, lamp_w, fault, blink
  );
endinterface

// File: rtl/traffic_lamp_driver.sv
// Registers and decodes per-approach light codes into lamp vectors; a persistent
// N/S vs E/W permission conflict latches a flashing-red fault until cleared.
module traffic_lamp_driver #(
  parameter int BLINK_DIV       = 25,
  parameter int CONFLICT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  traffic_lamp_driver_if.slave bus
);

  localparam int CW = $clog2(CONFLICT_CYCLES + 1);
  localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [1:0] CODE_RED = 2'd2;
  localparam logic [3:0] LAMP_RED = 4'b0001;

  typedef enum logic {NORMAL, FAULT} state_t;

  function automatic logic [3:0] decode(input logic [1:0] code);
    logic [3:0] lamp;
    lamp = LAMP_RED;
    case (code)
      2'd0:    lamp = 4'b0100;
      2'd1:    lamp = 4'b0010;
      2'd2:    lamp = 4'b0001;
      default: lamp = 4'b1001;
    endcase
    return lamp;
  endfunction

  state_t          state_q;
  logic [CW-1:0]   conf_cnt_q, conf_cnt_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            blink_q, blink_d;
  logic            fault_q;
  logic [3:0]      lamp_q [4];
  logic [1:0]      code [4];
  logic [3:0]      dec [4];
  logic            conflict;
  logic            trip;
  logic            div_wrap;

  assign code[0] = bus.north;
  assign code[1] = bus.south;
  assign code[2] = bus.east;
  assign code[3] = bus.west;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    assign dec[gi] = decode(code[gi]);
  end

  assign conflict = ((bus.north != CODE_RED) || (bus.south != CODE_RED)) &&
                    ((bus.east  != CODE_RED) || (bus.west  != CODE_RED));

  always_comb begin
    conf_cnt_d = '0;
    if (conflict) begin
      if (conf_cnt_q == CW'(CONFLICT_CYCLES))
        conf_cnt_d = conf_cnt_q;
      else
        conf_cnt_d = conf_cnt_q + CW'(1);
    end
  end

  // Trip on the edge that samples the last conflict, so it never reaches the lamps.
  assign trip = (state_q == NORMAL) && conflict && (conf_cnt_d == CW'(CONFLICT_CYCLES));

  assign div_wrap  = (div_cnt_q == DW'(BLINK_DIV - 1));
  assign div_cnt_d = div_wrap ? '0 : div_cnt_q + DW'(1);
  assign blink_d   = div_wrap ? ~blink_q : blink_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      fault_q    <= 1'b0;
      blink_q    <= 1'b0;
      div_cnt_q  <= '0;
      conf_cnt_q <= '0;
      for (int i = 0; i < 4; i++) lamp_q[i] <= LAMP_RED;
    end else begin
      case (state_q)
        NORMAL: begin
          conf_cnt_q <= conf_cnt_d;
          if (trip) begin
            state_q   <= FAULT;
            fault_q   <= 1'b1;
            blink_q   <= 1'b1;
            div_cnt_q <= '0;
            for (int i = 0; i < 4; i++) lamp_q[i] <= LAMP_RED;
          end else begin
            blink_q   <= blink_d;
            div_cnt_q <= div_cnt_d;
            for (int i = 0; i < 4; i++) lamp_q[i] <= dec[i];
          end
        end
        default: begin
          // Prescaler keeps running across the exit edge.
          blink_q   <= blink_d;
          div_cnt_q <= div_cnt_d;
          if (bus.fault_clr && !conflict) begin
            state_q    <= NORMAL;
            fault_q    <= 1'b0;
            conf_cnt_q <= '0;
            for (int i = 0; i < 4; i++) lamp_q[i] <= dec[i];
          end else begin
            conf_cnt_q <= conf_cnt_d;
            for (int i = 0; i < 4; i++) lamp_q[i] <= {3'b000, blink_d};
          end
        end
      endcase
    end
  end

  assign bus.lamp_n = lamp_q[0];
  assign bus.lamp_s = lamp_q[1];
  assign bus.lamp_e = lamp_q[2];
  assign bus.lamp_w = lamp_q[3];
  assign bus.fault  = fault_q;
  assign bus.blink  = blink_q;

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Directed bench for traffic_lamp_driver with BLINK_DIV=4, CONFLICT_CYCLES=2:
// reset, decode, transient filtering, trip/flash, clear and reset mid-fault.
module tb_traffic_lamp_driver;
  localparam logic [1:0] G = 2'd0, Y = 2'd1, R = 2'd2, L = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  traffic_lamp_driver_if bus ();

  traffic_lamp_driver #(.BLINK_DIV(4), .CONFLICT_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] n, input logic [1:0] s,
                       input logic [1:0] e, input logic [1:0] w, input logic clr);
    bus.north = n; bus.south = s; bus.east = e; bus.west = w; bus.fault_clr = clr;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    $display("[TB] %s: observed %b expected %b", tag, obs, exp);
  endtask

  initial begin
    logic exp_blink;
    drive(G, G, G, G, 1'b0);
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_lamp_n", bus.lamp_n, 4'b0001);
    chk("rst_lamp_e", bus.lamp_e, 4'b0001);
    chk("rst_fault", {3'b0, bus.fault}, 4'd0);
    chk("rst_blink", {3'b0, bus.blink}, 4'd0);

    rst_n = 1'b1;
    drive(G, G, R, R, 1'b0);
    step();
    chk("rel_lamp_n", bus.lamp_n, 4'b0100);
    chk("rel_lamp_s", bus.lamp_s, 4'b0100);
    chk("rel_lamp_e", bus.lamp_e, 4'b0001);
    chk("rel_lamp_w", bus.lamp_w, 4'b0001);

    drive(R, R, L, L, 1'b0);
    step();
    chk("left_lamp_e", bus.lamp_e, 4'b1001);
    chk("left_lamp_w", bus.lamp_w, 4'b1001);
    chk("left_lamp_n", bus.lamp_n, 4'b0001);
    drive(R, R, Y, Y, 1'b1);
    step();
    chk("yel_lamp_e", bus.lamp_e, 4'b0010);
    chk("yel_fault", {3'b0, bus.fault}, 4'd0);

    // Two isolated one-cycle conflicts: counter must clear in between.
    for (int k = 0; k < 2; k++) begin
      drive(G, R, Y, R, 1'b0);
      step();
      chk("trans_lamp_n", bus.lamp_n, 4'b0100);
      chk("trans_lamp_e", bus.lamp_e, 4'b0010);
      chk("trans_fault", {3'b0, bus.fault}, 4'd0);
      drive(R, R, Y, R, 1'b0);
      step();
      chk("trans_after_fault", {3'b0, bus.fault}, 4'd0);
      chk("trans_after_lamp_n", bus.lamp_n, 4'b0001);
    end

    drive(G, R, Y, R, 1'b0);
    step();
    chk("trip1_fault", {3'b0, bus.fault}, 4'd0);
    chk("trip1_lamp_n", bus.lamp_n, 4'b0100);
    step();
    chk("trip2_fault", {3'b0, bus.fault}, 4'd1);
    chk("trip2_lamp_n", bus.lamp_n, 4'b0001);
    chk("trip2_lamp_e", bus.lamp_e, 4'b0001);
    chk("trip2_blink", {3'b0, bus.blink}, 4'd1);
    for (int j = 1; j <= 10; j++) begin
      exp_blink = ((j / 4) % 2) == 0;
      step();
      chk($sformatf("flash%0d_lamp_n", j), bus.lamp_n, {3'b000, exp_blink});
      chk($sformatf("flash%0d_lamp_w", j), bus.lamp_w, {3'b000, exp_blink});
      chk($sformatf("flash%0d_blink", j), {3'b0, bus.blink}, {3'b000, exp_blink});
    end

    drive(G, R, Y, R, 1'b1);
    step();
    chk("clr_blocked_fault", {3'b0, bus.fault}, 4'd1);
    drive(R, R, G, G, 1'b1);
    step();
    chk("clr_fault", {3'b0, bus.fault}, 4'd0);
    chk("clr_lamp_e", bus.lamp_e, 4'b0100);
    chk("clr_lamp_w", bus.lamp_w, 4'b0100);
    chk("clr_lamp_n", bus.lamp_n, 4'b0001);
    chk("clr_lamp_s", bus.lamp_s, 4'b0001);

    drive(G, R, Y, R, 1'b0);
    step();
    step();
    chk("refault_fault", {3'b0, bus.fault}, 4'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_fault", {3'b0, bus.fault}, 4'd0);
    chk("midrst_blink", {3'b0, bus.blink}, 4'd0);
    chk("midrst_lamp_n", bus.lamp_n, 4'b0001);
    chk("midrst_lamp_e", bus.lamp_e, 4'b0001);
    rst_n = 1'b1;
    step();
    chk("postrst_fault", {3'b0, bus.fault}, 4'd0);
    chk("postrst_lamp_n", bus.lamp_n, 4'b0100);
    drive(R, R, Y, R, 1'b0);
    step();
    chk("postrst2_fault", {3'b0, bus.fault}, 4'd0);
    chk("postrst2_lamp_e", bus.lamp_e, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
